// File: rtl/rgb_cmd_pkg.sv
// Shared opcodes and state encoding for the RGB command responder.
package rgb_cmd_pkg;

  localparam logic [7:0] OP_LOAD = 8'h4C;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] OP_ACK  = 8'h4B;
  localparam logic [7:0] OP_NAK  = 8'h3F;

  localparam int unsigned RESP_MAX = 4;

  typedef enum logic [2:0] {
    IDLE,
    RX_R,
    RX_G,
    RX_B,
    TX
  } state_t;

endpackage

// File: rtl/rgb_pwm.sv
// Free-running PWM counter with one registered comparator per colour channel.
module rgb_pwm #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0][PWM_BITS-1:0] duty,
  output logic [2:0]               led
);

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= '0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      for (int n = 0; n < 3; n++) begin
        led[n] <= (cnt < duty[n]);
      end
    end
  end

endmodule

// File: rtl/rgb_cmd_responder.sv
// Byte-stream command responder: 'L' r g b sets LED duties, 'R' reads them back,
// anything else is answered with '?'.
module rgb_cmd_responder
  import rgb_cmd_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned TIMEOUT  = 48000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic [2:0] led_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t                      state_q, state_d;
  logic [1:0][7:0]             shadow_q, shadow_d;
  logic [2:0][7:0]             duty_q, duty_d;
  logic [RESP_MAX-1:0][7:0]    resp_q, resp_d;
  logic [1:0]                  last_q, last_d;
  logic [1:0]                  idx_q, idx_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [7:0]                  data_d;
  logic                        in_valid_d, out_ready_d;
  logic                        out_acc, in_acc;
  logic [2:0][PWM_BITS-1:0]    pwm_duty;

  assign out_acc = out_valid_i && out_ready_o;
  assign in_acc  = in_valid_o && in_ready_i;

  // Duty byte occupies the top of the PWM word; narrower counters keep its MSBs.
  function automatic logic [PWM_BITS-1:0] scale(input logic [7:0] b);
    logic [PWM_BITS+7:0] wide;
    wide = {b, PWM_BITS'(0)};
    return wide[PWM_BITS+7 -: PWM_BITS];
  endfunction

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      pwm_duty[n] = scale(duty_q[n]);
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    resp_d   = resp_q;
    last_d   = last_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    data_d   = in_data_o;

    case (state_q)
      IDLE: begin
        if (out_acc) begin
          idx_d = 2'd0;
          if (out_data_i == OP_LOAD) begin
            state_d = RX_R;
            tmo_d   = '0;
          end else if (out_data_i == OP_READ) begin
            resp_d[0] = OP_READ;
            resp_d[1] = duty_q[0];
            resp_d[2] = duty_q[1];
            resp_d[3] = duty_q[2];
            last_d    = 2'd3;
            state_d   = TX;
          end else begin
            resp_d[0] = OP_NAK;
            last_d    = 2'd0;
            state_d   = TX;
          end
        end
      end
      RX_R, RX_G, RX_B: begin
        if (out_acc) begin
          tmo_d = '0;
          if (state_q == RX_R) begin
            shadow_d[0] = out_data_i;
            state_d     = RX_G;
          end else if (state_q == RX_G) begin
            shadow_d[1] = out_data_i;
            state_d     = RX_B;
          end else begin
            // All three duties switch together on the final byte.
            duty_d[0] = shadow_q[0];
            duty_d[1] = shadow_q[1];
            duty_d[2] = out_data_i;
            resp_d[0] = OP_ACK;
            last_d    = 2'd0;
            idx_d     = 2'd0;
            state_d   = TX;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      TX: begin
        if (in_acc) begin
          if (idx_q == last_q) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_valid_d  = (state_d == TX);
    out_ready_d = (state_d != TX);
    if (state_d == TX) begin
      data_d = resp_d[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      duty_q      <= '0;
      resp_q      <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      in_data_o   <= '0;
      in_valid_o  <= 1'b0;
      out_ready_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      duty_q      <= duty_d;
      resp_q      <= resp_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      in_data_o   <= data_d;
      in_valid_o  <= in_valid_d;
      out_ready_o <= out_ready_d;
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk_i),
    .rst  (rst_i),
    .duty (pwm_duty),
    .led  (led_o)
  );

endmodule

// File: tb/tb_rgb_cmd_responder.sv
// Self-checking bench for rgb_cmd_responder against a byte-level command model.
module tb_rgb_cmd_responder;

  localparam int unsigned TB_TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] out_data = 8'h00;
  logic       out_valid = 1'b0;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready = 1'b0;
  logic [2:0] led_o;

  int errors = 0;
  int checks = 0;

  // Reference model: current duties, partial 'L' frame, and expected response.
  logic [7:0] m_duty [3];
  logic [7:0] m_frame [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int hold_viol;
  int ready_viol;

  always #5 clk = ~clk;

  rgb_cmd_responder #(
    .PWM_BITS(8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready),
    .led_o       (led_o)
  );

  task automatic model_byte(input logic [7:0] b);
    if (m_frame.size() == 0) begin
      if (b == 8'h4C) m_frame.push_back(b);
      else if (b == 8'h52) exp_q = '{8'h52, m_duty[0], m_duty[1], m_duty[2]};
      else exp_q = '{8'h3F};
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == 4) begin
        for (int n = 0; n < 3; n++) m_duty[n] = m_frame[n+1];
        exp_q = '{8'h4B};
        m_frame.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    out_data  = b;
    out_valid = 1'b1;
    while (out_ready_o !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL send_ready_timeout: out_ready_o=%b, required 1", out_ready_o);
    end
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle 1/0, 2: random
  task automatic collect(input int n, input int mode);
    logic [7:0] prev = 8'h00;
    bit have_prev = 1'b0;
    int cyc = 0;
    bit rdy;
    got_q.delete(); hold_viol = 0; ready_viol = 0;
    while (got_q.size() < n && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      in_ready = rdy;
      if (in_valid_o && out_ready_o) ready_viol++;
      if (in_valid_o && have_prev && in_data_o !== prev) hold_viol++;
      if (in_valid_o && rdy) begin
        got_q.push_back(in_data_o); have_prev = 1'b0;
      end else if (in_valid_o) begin
        prev = in_data_o; have_prev = 1'b1;
      end
      @(posedge clk); #1; cyc++;
    end
    in_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; out_valid = 1'b0; in_ready = 1'b0;
    for (int n = 0; n < 3; n++) m_duty[n] = 8'h00;
    m_frame.delete();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (out_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", out_ready_o); end
    checks++;
    if (in_valid_o !== 1'b0 || in_data_o !== 8'h00) begin
      errors++; $display("FAIL reset_in: valid=%b data=%h, required 0/00", in_valid_o, in_data_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", out_ready_o); end
    checks++;
    if (led_o !== 3'b000 || in_valid_o !== 1'b0) begin
      errors++; $display("FAIL release_idle: led=%b valid=%b, required 000/0", led_o, in_valid_o);
    end
  endtask

  task automatic test_set_color();
    logic [7:0] seq [4] = '{8'h4C, 8'hFF, 8'h80, 8'h00};
    int hi [3] = '{0, 0, 0};
    int vcnt = 0;
    exp_q.delete();
    foreach (seq[i]) begin model_byte(seq[i]); send_byte(seq[i]); end
    checks++;
    if (in_valid_o !== 1'b1) begin errors++; $display("FAIL set_latency: in_valid=%b, required 1", in_valid_o); end
    collect(1, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h4B) begin
      errors++; $display("FAIL set_resp: got %0d bytes first=%h, required 1 byte 4B", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    repeat (4) begin vcnt += int'(in_valid_o); @(posedge clk); #1; end
    checks++;
    if (vcnt != 0) begin errors++; $display("FAIL set_extra: %0d extra valid cycles, required 0", vcnt); end
    repeat (256) begin
      for (int n = 0; n < 3; n++) hi[n] += int'(led_o[n]);
      @(posedge clk); #1;
    end
    checks++;
    if (hi[0] != 255 || hi[1] != 128 || hi[2] != 0) begin
      errors++; $display("FAIL set_pwm: r=%0d g=%0d b=%0d, required 255/128/0", hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_read_back();
    exp_q.delete();
    model_byte(8'h52); send_byte(8'h52);
    collect(4, 1);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL read_len: got %0d bytes, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL read_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL read_hold: %0d unstable cycles, required 0", hold_viol); end
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL read_ready_tx: %0d cycles ready in TX, required 0", ready_viol); end
  endtask

  task automatic test_timeout();
    int vcnt = 0;
    logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
    exp_q.delete();
    model_byte(8'h4C); send_byte(8'h4C);
    model_byte(8'h10); send_byte(8'h10);
    repeat (TB_TIMEOUT + 10) begin vcnt += int'(in_valid_o); @(posedge clk); #1; end
    m_frame.delete();
    checks++;
    if (vcnt != 0 || out_ready_o !== 1'b1) begin
      errors++; $display("FAIL timeout_quiet: valid cycles=%0d ready=%b, required 0/1", vcnt, out_ready_o);
    end
    exp_q.delete();
    model_byte(8'h52); send_byte(8'h52);
    collect(4, 0);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("FAIL timeout_read: got %p, required %p", got_q, exp_q);
    end
    // Gaps just under the limit must not abandon the frame.
    exp_q.delete();
    model_byte(8'h4C); send_byte(8'h4C);
    foreach (seq[i]) begin
      repeat (TB_TIMEOUT - 10) @(posedge clk); #1;
      model_byte(seq[i]); send_byte(seq[i]);
    end
    collect(1, 0);
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL timeout_gap_ack: got %p, required %p", got_q, exp_q); end
  endtask

  task automatic test_unknown_and_reset();
    logic [7:0] seq [4] = '{8'h4C, 8'hFF, 8'hFF, 8'hFF};
    int vcnt = 0;
    exp_q.delete();
    foreach (seq[i]) begin model_byte(seq[i]); send_byte(seq[i]); end
    collect(1, 0);
    exp_q.delete();
    model_byte(8'h7A); send_byte(8'h7A);
    checks++;
    if (out_ready_o !== 1'b0 || in_valid_o !== 1'b1) begin
      errors++; $display("FAIL nak_tx: ready=%b valid=%b, required 0/1", out_ready_o, in_valid_o);
    end
    collect(1, 2);
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL nak_resp: got %p, required %p", got_q, exp_q); end
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL nak_ready_tx: %0d cycles, required 0", ready_viol); end
    send_byte(8'h52);
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_valid_o !== 1'b0 || led_o !== 3'b000) begin
      errors++; $display("FAIL midreset: valid=%b led=%b, required 0/000", in_valid_o, led_o);
    end
    rst_i = 1'b0;
    in_ready = 1'b1;
    repeat (6) begin vcnt += int'(in_valid_o); @(posedge clk); #1; end
    in_ready = 1'b0;
    checks++;
    if (vcnt != 0) begin errors++; $display("FAIL midreset_abandon: %0d valid cycles, required 0", vcnt); end
    for (int n = 0; n < 3; n++) m_duty[n] = 8'h00;
    m_frame.delete();
    exp_q.delete();
    model_byte(8'h52); send_byte(8'h52);
    collect(4, 0);
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL midreset_duties: got %p, required %p", got_q, exp_q); end
  endtask

  task automatic test_random();
    int hi [3] = '{0, 0, 0};
    logic [7:0] b;
    for (int it = 0; it < 20; it++) begin
      int kind = int'($urandom_range(0, 2));
      exp_q.delete();
      if (kind == 0) begin
        model_byte(8'h4C); send_byte(8'h4C);
        for (int k = 0; k < 3; k++) begin
          b = 8'($urandom_range(0, 255));
          model_byte(b); send_byte(b);
        end
      end else if (kind == 1) begin
        model_byte(8'h52); send_byte(8'h52);
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h4C || b == 8'h52);
        model_byte(b); send_byte(b);
      end
      checks++;
      if (in_valid_o !== 1'b1) begin errors++; $display("FAIL rand%0d_latency: valid=%b, required 1", it, in_valid_o); end
      collect(exp_q.size(), 2);
      checks++;
      if (got_q != exp_q || hold_viol != 0) begin
        errors++; $display("FAIL rand%0d_resp: got %p hold_viol=%0d, required %p 0", it, got_q, hold_viol, exp_q);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk); #1;
    repeat (256) begin
      for (int n = 0; n < 3; n++) hi[n] += int'(led_o[n]);
      @(posedge clk); #1;
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (hi[n] != int'(m_duty[n])) begin
        errors++; $display("FAIL rand_pwm%0d: high %0d cycles, required %0d", n, hi[n], m_duty[n]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_color();
    test_read_back();
    test_timeout();
    test_unknown_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_cmd_responder.md
RGB_CMD_RESPONDER -- requirements
Module: rgb_cmd_responder

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the duty/PWM counter width.
REQ-002 SHALL have parameter TIMEOUT, default 48000, giving the inter-byte timeout in clk_i cycles (1 ms at 48 MHz).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port out_data_i  input  8  host-to-device byte from the usb_cdc out stream.
REQ-006 SHALL have port out_valid_i  input  1  out_data_i holds a valid byte.
REQ-007 SHALL have port out_ready_o  output  1  responder accepts a byte this cycle.
REQ-008 SHALL have port in_data_o  output  8  device-to-host response byte to the usb_cdc in stream.
REQ-009 SHALL have port in_valid_o  output  1  in_data_o holds a valid byte.
REQ-010 SHALL have port in_ready_i  input  1  usb_cdc accepts in_data_o this cycle.
REQ-011 SHALL have port led_o  output  3  PWM drive; bit0 red, bit1 green, bit2 blue.

Function
REQ-012 SHALL transfer a byte on either stream only in a cycle where valid and ready are both high.
REQ-013 SHALL use states IDLE, RX_R, RX_G, RX_B and TX.
REQ-014 SHALL drive out_ready_o high in IDLE/RX_*, low in TX; in_valid_o high only in TX.
REQ-015 In IDLE, accepted byte 0x4C ('L') SHALL go to RX_R; 0x52 ('R') SHALL load a response {0x52, dutyR, dutyG, dutyB} and go to TX; any other byte SHALL load the response {0x3F} and go to TX.
REQ-016 RX_R/RX_G/RX_B SHALL each capture one accepted byte into a shadow register, any value, advancing RX_R->RX_G->RX_B.
REQ-017 On accepting the byte in RX_B, the block SHALL copy all three shadow values into the duty registers in the same edge (atomic update), load the response {0x4B} and go to TX.
REQ-018 When PWM_BITS > 8, the block SHALL place each received duty byte in the upper 8 bits and zero-fill the lower bits; when PWM_BITS < 8, it SHALL use the upper PWM_BITS bits.
REQ-019 In TX, in_data_o SHALL hold the current response byte stable until it is accepted; on acceptance the block SHALL advance the byte index; after the last byte is accepted it SHALL enter IDLE on the next cycle.
REQ-020 The first response byte SHALL be presented on the cycle after the triggering byte is accepted (1-cycle latency).
REQ-021 A timeout counter SHALL count cycles in RX_* with no accepted byte; it SHALL clear on each accepted byte and on entry to RX_R.
REQ-022 When the count reaches TIMEOUT, the block SHALL discard the partial frame, leave the duties unchanged, send no response and return to IDLE.
REQ-023 An accepted byte in the same cycle as the timeout SHALL take priority, and the timeout SHALL NOT fire.
REQ-024 A free-running PWM_BITS counter SHALL wrap from all-ones to 0; led_o[n] SHALL be registered as (cnt < duty[n]).
REQ-025 Duty 0 SHALL give a constantly low LED; all-ones duty SHALL give a LED high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-026 A duty change SHALL take effect at the next comparison, without waiting for the counter to wrap.

Reset
REQ-027 While rst_i is high, the block SHALL hold: state IDLE, duties and shadows 0, PWM and timeout counters 0, led_o 000, in_valid_o 0, in_data_o 0x00, out_ready_o 0.
REQ-028 out_ready_o SHALL rise on the first cycle after rst_i deasserts.
REQ-029 Reset asserted mid-frame or mid-response SHALL abandon the frame/response with no further in_valid_o.

Structure
REQ-030 Opcode constants (0x4C, 0x52, 0x4B, 0x3F) and the state encoding SHALL live in shared package rgb_cmd_pkg.
REQ-031 The PWM counter and comparators SHALL be one sub-module, rgb_pwm, parameterised by PWM_BITS.

Verification
REQ-032 The bench SHALL cover: reset release -> out_ready_o=1 on the first cycle after, led_o=000, in_valid_o=0.
REQ-033 The bench SHALL cover: bytes 4C,FF,80,00 -> single response 4B; red duty FF, green 80, blue 00; over 256 cycles red high 255, green 128, blue 0.
REQ-034 The bench SHALL cover: after REQ-033, byte 52 with in_ready_i toggling 1/0 -> response 52,FF,80,00 in order, each byte held stable while in_ready_i=0.
REQ-035 The bench SHALL cover: bytes 4C,10 then idle for TIMEOUT cycles -> no response, state IDLE, duties unchanged; then 52 -> response 52,FF,80,00.
REQ-036 The bench SHALL cover: byte 7A -> response 3F; out_ready_o=0 during TX; rst_i pulse mid-response -> in_valid_o=0 and led_o=000 next cycle.
